// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its command front end.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_MUL  = 3'b010;
    localparam logic [2:0] OP_AND  = 3'b011;
    localparam logic [2:0] OP_OR   = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_NOR  = 3'b110;
    localparam logic [2:0] OP_XOR  = 3'b111;

    // One bit per opcode; set for opcodes whose carry flag is meaningful.
    localparam logic [7:0] ARITH_OPS = (8'b1 << OP_ADD) | (8'b1 << OP_SUB);

    // FIFO entry layout {opcode, a, b}, 19 bits.
    typedef struct packed {
        logic [2:0] opcode;
        logic [7:0] a;
        logic [7:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return ARITH_OPS[op];
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; pointers carry one extra wrap bit to tell full from empty.
module cmd_fifo
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cmd_t wdata,
    input  logic pop,
    output cmd_t rdata,
    output logic full,
    output logic empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cmd_t          mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Pointer advance; cleared by reset so the FIFO comes up empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command front end for the 8-bit ALU: queues commands, issues them one at a
// time, captures result/flags and returns them in order over a ready/valid channel.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_opcode,
    input  logic [7:0]  cmd_a,
    input  logic [7:0]  cmd_b,
    output logic [2:0]  alu_opcode,
    output logic [7:0]  alu_in1,
    output logic [7:0]  alu_in2,
    input  logic [15:0] alu_result,
    input  logic        alu_flagc,
    input  logic        alu_flagz,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [2:0]  rsp_opcode,
    output logic [15:0] rsp_result,
    output logic        rsp_flagc,
    output logic        rsp_flagz,
    output logic        busy,
    output logic [15:0] op_count
);

    state_t state;
    cmd_t   in_cmd;
    cmd_t   head;
    logic   fifo_full;
    logic   fifo_empty;
    logic   push;
    logic   pop;

    assign in_cmd    = '{opcode: cmd_opcode, a: cmd_a, b: cmd_b};
    assign cmd_ready = !fifo_full;
    assign push      = cmd_valid && !fifo_full;
    assign pop       = (state == IDLE) && !fifo_empty;
    assign busy      = !fifo_empty || (state != IDLE);

    cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (in_cmd),
        .pop   (pop),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Issue FSM: pop into ALU operand registers, capture ALU outputs, hold response until accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            alu_opcode <= '0;
            alu_in1    <= '0;
            alu_in2    <= '0;
            rsp_valid  <= 1'b0;
            rsp_opcode <= '0;
            rsp_result <= '0;
            rsp_flagc  <= 1'b0;
            rsp_flagz  <= 1'b0;
            op_count   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        alu_opcode <= head.opcode;
                        alu_in1    <= head.a;
                        alu_in2    <= head.b;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    // ALU keeps a stale carry on logic/MUL ops, so only ADD/SUB pass it through.
                    rsp_opcode <= alu_opcode;
                    rsp_result <= alu_result;
                    rsp_flagz  <= alu_flagz;
                    rsp_flagc  <= alu_flagc && is_arith(alu_opcode);
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        op_count  <= op_count + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Self-checking bench for alu_cmd_issuer with a behavioural ALU stub and a
// queue-based scoreboard of expected responses.
module tb_alu_cmd_issuer;
    import alu_pkg::*;

    typedef struct packed {
        logic [2:0]  opcode;
        logic [15:0] result;
        logic        flagc;
        logic        flagz;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [7:0]  cmd_a;
    logic [7:0]  cmd_b;
    logic [2:0]  alu_opcode;
    logic [7:0]  alu_in1;
    logic [7:0]  alu_in2;
    logic [15:0] alu_result;
    logic        alu_flagc;
    logic        alu_flagz;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [2:0]  rsp_opcode;
    logic [15:0] rsp_result;
    logic        rsp_flagc;
    logic        rsp_flagz;
    logic        busy;
    logic [15:0] op_count;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    exp_t        model_q[$];
    cmd_t        stim_q[$];
    int unsigned exp_cnt = 0;

    alu_cmd_issuer #(
        .DEPTH (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_a      (cmd_a),
        .cmd_b      (cmd_b),
        .alu_opcode (alu_opcode),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_result (alu_result),
        .alu_flagc  (alu_flagc),
        .alu_flagz  (alu_flagz),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_opcode (rsp_opcode),
        .rsp_result (rsp_result),
        .rsp_flagc  (rsp_flagc),
        .rsp_flagz  (rsp_flagz),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural ALU: returns {raw carry, result}. Non-arithmetic ops leave
    // carry stuck at 1 to imitate the real ALU's stale carry.
    function automatic logic [16:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        case (op)
            OP_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                return {s[8], 7'd0, s};
            end
            OP_SUB:  return {a < b, 16'(a) - 16'(b)};
            OP_MUL:  return {1'b1, 16'(a) * 16'(b)};
            OP_AND:  return {1'b1, 8'h00, a & b};
            OP_OR:   return {1'b1, 8'h00, a | b};
            OP_NAND: return {1'b1, 8'h00, ~(a & b)};
            OP_NOR:  return {1'b1, 8'h00, ~(a | b)};
            default: return {1'b1, 8'h00, a ^ b};
        endcase
    endfunction

    function automatic exp_t expect_for(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [16:0] r;
        exp_t e;
        r = alu_ref(op, a, b);
        e.opcode = op;
        e.result = r[15:0];
        e.flagc  = (op == OP_ADD || op == OP_SUB) ? r[16] : 1'b0;
        e.flagz  = (r[15:0] == 16'h0000);
        return e;
    endfunction

    always_comb begin
        {alu_flagc, alu_result} = alu_ref(alu_opcode, alu_in1, alu_in2);
        alu_flagz = (alu_result == 16'h0000);
    end

    // Scoreboard: handshakes are decided at the coming posedge, inputs are stable at negedge.
    logic        prev_valid = 1'b0;
    logic        prev_hs    = 1'b0;
    exp_t        prev_rsp;
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            model_q.delete();
            exp_cnt    = 0;
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            check_eq("op_count", 32'(op_count), 32'(exp_cnt[15:0]));
            check_eq("busy", 32'(busy), 32'(model_q.size() != 0));
            if (prev_valid && !prev_hs) begin
                check_eq("rsp_valid_held", 32'(rsp_valid), 32'd1);
                check_eq("rsp_stable", 32'({rsp_opcode, rsp_result, rsp_flagc, rsp_flagz}), 32'(prev_rsp));
            end
            if (rsp_valid && rsp_ready) begin
                if (model_q.size() == 0) begin
                    check_eq("rsp_unexpected", 32'(rsp_valid), 32'd0);
                end else begin
                    e = model_q.pop_front();
                    check_eq("rsp_opcode", 32'(rsp_opcode), 32'(e.opcode));
                    check_eq("rsp_result", 32'(rsp_result), 32'(e.result));
                    check_eq("rsp_flagc", 32'(rsp_flagc), 32'(e.flagc));
                    check_eq("rsp_flagz", 32'(rsp_flagz), 32'(e.flagz));
                end
                exp_cnt++;
            end
            if (cmd_valid && cmd_ready) model_q.push_back(expect_for(cmd_opcode, cmd_a, cmd_b));
            prev_valid = rsp_valid;
            prev_hs    = rsp_valid && rsp_ready;
            prev_rsp   = '{opcode: rsp_opcode, result: rsp_result, flagc: rsp_flagc, flagz: rsp_flagz};
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Offer queued commands; each held until accepted.
    task automatic run_stream(input int unsigned cycles, input int unsigned vpct, input int unsigned rpct);
        cmd_t cur;
        logic acc;
        for (int unsigned i = 0; i < cycles && stim_q.size() != 0; i++) begin
            cur        = stim_q[0];
            cmd_valid  = ($urandom_range(99) < vpct);
            cmd_opcode = cur.opcode;
            cmd_a      = cur.a;
            cmd_b      = cur.b;
            rsp_ready  = ($urandom_range(99) < rpct);
            acc        = cmd_valid && cmd_ready;
            @(posedge clk);
            #1;
            if (acc) void'(stim_q.pop_front());
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int unsigned n;
        rsp_ready = 1'b1;
        n = 0;
        while ((model_q.size() != 0 || busy) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check_eq("drain_left", 32'(model_q.size()), 32'd0);
    endtask

    // Single command from idle with fixed expectations and cycle-exact latency.
    task automatic run_one(input string tag, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [15:0] res, input logic c, input logic z);
        logic [15:0] base;
        base       = op_count;
        rsp_ready  = 1'b1;
        cmd_opcode = op;
        cmd_a      = a;
        cmd_b      = b;
        cmd_valid  = 1'b1;
        check_eq({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        check_eq({tag, "_v_e0"}, 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_v_e1"}, 32'(rsp_valid), 32'd0);
        @(posedge clk);
        #1;
        check_eq({tag, "_v_e2"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_res"}, 32'(rsp_result), 32'(res));
        check_eq({tag, "_c"}, 32'(rsp_flagc), 32'(c));
        check_eq({tag, "_z"}, 32'(rsp_flagz), 32'(z));
        @(posedge clk);
        #1;
        check_eq({tag, "_v_e3"}, 32'(rsp_valid), 32'd0);
        check_eq({tag, "_cnt"}, 32'(op_count), 32'(base + 16'd1));
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.opcode = 3'($urandom_range(7));
        c.a      = 8'($urandom_range(255));
        c.b      = 8'($urandom_range(255));
        return c;
    endfunction

    initial begin
        rst = 1'b1; cmd_valid = 1'b0; cmd_opcode = '0; cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
        do_reset();

        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_alu", 32'({alu_opcode, alu_in1, alu_in2}), 32'd0);
        check_eq("rst_rsp", 32'({rsp_opcode, rsp_result, rsp_flagc, rsp_flagz}), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_op_count", 32'(op_count), 32'd0);

        run_one("add", OP_ADD, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0);
        check_eq("add_op_count", 32'(op_count), 32'd1);
        run_one("sub", OP_SUB, 8'h05, 8'h05, 16'h0000, 1'b0, 1'b1);
        run_one("mul", OP_MUL, 8'h10, 8'h10, 16'h0100, 1'b0, 1'b0);
        run_one("add2", OP_ADD, 8'hFF, 8'h01, 16'h0100, 1'b1, 1'b0);
        run_one("and", OP_AND, 8'h0F, 8'hF0, 16'h0000, 1'b0, 1'b1);

        // Backpressure: six commands, consumer stalled.
        do_reset();
        for (int i = 0; i < 6; i++) stim_q.push_back(cmd_t'({OP_ADD + 3'(i), 8'(8'h11 * (i + 1)), 8'(8'h23 + i)}));
        run_stream(10, 100, 0);
        check_eq("stall_pending", 32'(stim_q.size()), 32'd1);
        check_eq("stall_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("stall_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("stall_rsp_opcode", 32'(rsp_opcode), 32'(OP_ADD));
        run_stream(60, 100, 100);
        check_eq("stall_all_sent", 32'(stim_q.size()), 32'd0);
        drain();
        check_eq("stall_op_count", 32'(op_count), 32'd6);

        // Reset while holding a response with two commands queued.
        do_reset();
        for (int i = 0; i < 3; i++) stim_q.push_back(cmd_t'({OP_OR, 8'h5A, 8'(8'h81 + i)}));
        run_stream(8, 100, 0);
        check_eq("mid_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("mid_queued", 32'(model_q.size()), 32'd3);
        rst = 1'b1;
        #1;
        check_eq("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("mid_rst_op_count", 32'(op_count), 32'd0);
        check_eq("mid_rst_alu", 32'({alu_opcode, alu_in1, alu_in2}), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        rsp_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_eq("mid_no_stale", 32'(rsp_valid), 32'd0);
        check_eq("mid_idle_busy", 32'(busy), 32'd0);

        // Continuous push with consumer always ready.
        for (int i = 0; i < 30; i++) stim_q.push_back(rand_cmd());
        run_stream(300, 100, 100);
        check_eq("cont_all_sent", 32'(stim_q.size()), 32'd0);
        drain();
        check_eq("cont_op_count", 32'(op_count), 32'd30);

        // Random valid/ready traffic.
        for (int i = 0; i < 150; i++) stim_q.push_back(rand_cmd());
        run_stream(4000, 70, 60);
        check_eq("rand_all_sent", 32'(stim_q.size()), 32'd0);
        drain();
        check_eq("rand_op_count", 32'(op_count), 32'd180);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Sequential front end for the 8-bit combinational ALU. It accepts ALU commands over a valid/ready handshake, buffers them in a small FIFO, and drives the ALU's opcode and operand inputs one command at a time. It captures the ALU's result and flags, then returns them in order over a valid/ready response channel with backpressure. It sits between the command source (sequencer or bus bridge) and the ALU instance.

## Interface
- DEPTH, 4, command FIFO depth; power of 2, minimum 2
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (= !full)
- cmd_opcode  in  3  ADD=000 SUB=001 MUL=010 AND=011 OR=100 NAND=101 NOR=110 XOR=111
- cmd_a  in  8  operand 1
- cmd_b  in  8  operand 2
- alu_opcode  out  3  to ALU opcode, registered
- alu_in1  out  8  to ALU in1, registered
- alu_in2  out  8  to ALU in2, registered
- alu_result  in  16  from ALU
- alu_flagc  in  1  from ALU carry flag
- alu_flagz  in  1  from ALU zero flag
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts response
- rsp_opcode  out  3  opcode of this response
- rsp_result  out  16  captured result
- rsp_flagc  out  1  captured carry, masked
- rsp_flagz  out  1  captured zero
- busy  out  1  FIFO non-empty or FSM not IDLE
- op_count  out  16  completed responses, wraps

## Operation
- Command push on clk edge with cmd_valid && cmd_ready. Order is strictly preserved.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: if FIFO non-empty, pop head into the alu_* registers and go to EXEC; otherwise stay.
  - EXEC: the ALU output has settled. Capture alu_result, alu_flagz and alu_flagc into the rsp_* registers, set rsp_valid, go to RESP.
  - RESP: hold all rsp_* stable while rsp_valid && !rsp_ready. On handshake, clear rsp_valid, increment op_count and go to IDLE.
- Carry masking: rsp_flagc = alu_flagc only for ADD/SUB; it is forced to 0 for every other opcode. The ALU holds a stale carry on non-arithmetic ops.
- alu_* outputs hold their last popped values between commands; they never return to 0 except on reset.
- op_count wraps 0xFFFF -> 0x0000.
- Simultaneous push and pop in one cycle (FIFO not full): both take effect and occupancy is unchanged.
- Push while full is impossible (cmd_ready low). Pop while empty does not occur.
- Full: cmd_ready deasserts the same cycle occupancy reaches DEPTH, with no lookahead.
- Reset mid-operation: FIFO is emptied, in-flight command and pending response are dropped, FSM goes to IDLE.

## Timing
- Reset values:
  - cmd_ready=1
  - alu_opcode=000, alu_in1=0, alu_in2=0
  - rsp_valid=0, rsp_opcode=0, rsp_result=0, rsp_flagc=0, rsp_flagz=0
  - busy=0, op_count=0
  - FSM=IDLE, FIFO empty
- Latency with an empty FIFO and IDLE FSM:
  - command accepted at edge E0
  - popped to alu_* at E1
  - captured at E2, so rsp_valid is high after E2
  - with rsp_ready held high, the response handshakes at E3
- Throughput: one command per 3 cycles at best.
- rsp_valid never drops without a handshake (except on reset). rsp_* never change while rsp_valid is high.
- cmd_ready and rsp_valid are driven from registers/occupancy only. There is no combinational path from cmd_valid or rsp_ready.

## Structure
- Shared package alu_pkg:
  - opcode localparams ADD..XOR, shared with the ALU
  - state enum IDLE/EXEC/RESP
  - helper constant for the arithmetic-opcode set {ADD, SUB} used for carry masking
- Sub-module cmd_fifo: synchronous FIFO, parameter DEPTH, 19-bit entries {opcode, a, b}, full/empty outputs, same clk/rst.
- The FSM, result registers and op_count live in alu_cmd_issuer.

## Test plan
- ADD a=0xFF b=0x01, rsp_ready=1 -> rsp_result=0x0100, flagc=1, flagz=0; rsp_valid rises 2 cycles after acceptance; op_count=1.
- SUB a=0x05 b=0x05 -> rsp_result=0x0000, flagz=1, flagc=0. MUL a=0x10 b=0x10 -> 0x0100, flagc=0, flagz=0.
- ADD 0xFF+0x01 then AND 0x0F&0xF0 -> second response result=0x0000, flagz=1, flagc=0 (stale carry masked).
- rsp_ready=0, offer 6 commands back-to-back (DEPTH=4):
  - cmd1 goes into EXEC/RESP; cmds 2-5 fill the FIFO; cmd_ready drops; cmd6 stalls
  - rsp_* stay stable while stalled
  - release rsp_ready -> 6 responses in issue order; op_count=6
- Assert rst while in RESP with 2 entries queued -> next cycle: rsp_valid=0, busy=0, cmd_ready=1, op_count=0, alu_* = 0; no stale response afterwards.
- Continuous push with rsp_ready=1 -> simultaneous push/pop cycles keep occupancy constant; no lost or duplicated commands.
